ttt_game_ctrl: RTL
==================

# ttt_game_ctrl

Sequential N×N tic-tac-toe referee. It holds the board in registers, accepts alternating X/O moves over a valid/ready handshake, and rejects illegal moves. After each accepted move it evaluates N-in-a-row wins (rows, columns, both diagonals) and draws. It is the successor to the combinational 3×3 board checker, and sits between the move source (UI/AI) and the display/score logic.

## Interface
- N, default 3, board side length; legal range 3..8.
- CW, default $clog2(N), row/column index width (derived, not overridden).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  clears the board and begins a game (accepted in IDLE or DONE).
- move_valid  in  1  a move is presented.
- move_ready  out  1  high only in PLAY; a move is accepted on move_valid & move_ready.
- move_player  in  1  0 = X, 1 = O.
- move_row, move_col  in  CW each  target cell; cell index = row*N + col.
- board_x, board_o  out  N*N each  registered occupancy bitmaps.
- turn  out  1  player expected next (0 = X).
- move_count  out  $clog2(N*N+1)  accepted moves this game.
- err_range, err_occupied, err_turn  out  1 each  one-cycle pulses on a rejected move.
- win_x, win_o, draw  out  1 each  game result; held until start or rst.
- game_over  out  1  high in DONE.

## Operation
- States: IDLE, PLAY, CHECK, DONE.
- IDLE: start → PLAY. Board cleared, turn = X, move_count = 0.
- PLAY, handshake fires:
  - row ≥ N or col ≥ N → err_range.
  - else cell occupied in board_x | board_o → err_occupied.
  - else move_player ≠ turn → err_turn.
  - Priority is range > occupied > turn; exactly one error pulses.
  - Legal move: set the bit in the player's bitmap, increment move_count, toggle turn → CHECK.
  - Illegal move: board unchanged, stay in PLAY (see Configuration).
- CHECK: evaluate the N rows, N columns and 2 diagonals of the updated board.
  - Line of mover's bits complete → set win_x/win_o → DONE.
  - Else move_count == N*N → draw → DONE.
  - Else → PLAY.
- At most one of win_x, win_o, draw is ever high. No-win means none high; there is no separate no-win output.
- DONE: moves ignored (move_ready = 0). start → clear board and results → PLAY.
- start in PLAY/CHECK is ignored.
- rst in any state: return to IDLE, all registers cleared, mid-game moves discarded.

## Timing
- Reset values: move_ready 0, board_x/board_o 0, turn 0, move_count 0, all error pulses 0, win_x/win_o/draw 0, game_over 0.
- move_ready is a registered state decode; it is never combinationally dependent on move_valid.
- Move accepted at edge E: board/turn/move_count update at E; state = CHECK for cycle E..E+1, move_ready = 0.
- Result flags and game_over assert at edge E+1.
- Next move can be accepted at edge E+2 at the earliest; one move per 2 cycles.
- Error pulses assert at the edge after the rejected handshake, for exactly one cycle. A rejected move does not enter CHECK; the next move can be accepted at the following edge.
- start in IDLE/DONE at edge S: PLAY from S; move_ready high in the cycle after S.
- Simultaneous start and move_valid in DONE: start wins, the move is not accepted.

## Configuration
- TTT_FORFEIT_EN defined: an illegal move (any error) also ends the game. The opponent of move_player wins: err_turn and err_occupied award the opponent; for err_range, the opponent of the current turn wins. Error pulse and win flag assert on the same edge; state → DONE.
- TTT_FORFEIT_EN undefined: illegal move only pulses its error and the game stays in PLAY with the same turn.

## Test plan
- N=3: rst, start; X(0,0), O(0,1), X(1,1), O(0,2), X(2,2) → win_x = 1 and game_over = 1 one edge after the 5th acceptance; move_count = 5; move_ready = 0 afterwards.
- N=3: nine-move fill with no line (X at 0,2,3,7,8; O at 1,4,5,6) → draw = 1, win_x = win_o = 0, move_count = 9.
- N=3, forfeit off: X(1,1), then O(1,1) → err_occupied pulse for 1 cycle, board_o = 0, turn stays O; then X(0,0) → err_turn; then O(3,0) → err_range only.
- N=3, TTT_FORFEIT_EN: O moves first at (0,0) → err_turn and win_x on the same edge, game_over = 1.
- N=5: column 4 by X across 9 alternating moves → win_x after the 9th move; assert rst mid-game at move 4 of a rerun → all outputs 0, IDLE, move_ready = 0.
- DONE with start and move_valid on the same cycle → board cleared, move ignored, results cleared, move_ready = 1 the next cycle.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl -- sequential N x N tic-tac-toe referee.
//
// Holds the board in registers, accepts alternating X/O moves over a
// valid/ready handshake, rejects illegal moves with one-cycle error pulses,
// and after every accepted move spends one CHECK cycle evaluating rows,
// columns and both diagonals of the mover's bitmap for a win, then draw.
//
// Parameters:
//   N   board side, 3..8
//   CW  row/column index width (derived)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         clear board and begin a game (IDLE/DONE)
//   move_valid / move_ready       move handshake (ready only in PLAY)
//   move_player, move_row/col     mover (0 = X) and target cell
//   board_x, board_o              occupancy bitmaps, cell = row*N + col
//   turn, move_count              player expected next, accepted moves
//   err_range/occupied/turn       one-cycle pulses on a rejected move
//   win_x, win_o, draw, game_over game result, held until start/rst
//
// Build option: define TTT_FORFEIT_EN to make any illegal move end the game
// in favour of the opponent.
module ttt_game_ctrl #(
    parameter int N = 3,
    localparam int CW = (N > 1) ? $clog2(N) : 1,
    localparam int MCW = $clog2(N * N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic             move_player,
    input  logic [CW-1:0]    move_row,
    input  logic [CW-1:0]    move_col,
    output logic [N*N-1:0]   board_x,
    output logic [N*N-1:0]   board_o,
    output logic             turn,
    output logic [MCW-1:0]   move_count,
    output logic             err_range,
    output logic             err_occupied,
    output logic             err_turn,
    output logic             win_x,
    output logic             win_o,
    output logic             draw,
    output logic             game_over
);
    localparam int NN = N * N;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [NN-1:0]    board_x_q, board_x_d, board_o_q, board_o_d;
    logic             turn_q, turn_d;
    logic [MCW-1:0]   move_count_q, move_count_d;
    logic             err_range_q, err_range_d;
    logic             err_occupied_q, err_occupied_d;
    logic             err_turn_q, err_turn_d;
    logic             win_x_q, win_x_d, win_o_q, win_o_d, draw_q, draw_d;

    logic             range_bad, occupied, line_hit;
    int               cell_idx;
    logic [NN-1:0]    cell_mask, mover_bits;

    // kind 0: row k, 1: column k, 2: main diagonal, 3: anti-diagonal
    function automatic logic [NN-1:0] line_mask(input int kind, input int k);
        logic [NN-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       m = m | (NN'(1) << (k * N + i));
                1:       m = m | (NN'(1) << (i * N + k));
                2:       m = m | (NN'(1) << (i * N + i));
                default: m = m | (NN'(1) << (i * N + (N - 1 - i)));
            endcase
        end
        return m;
    endfunction

    // turn has already toggled when CHECK runs, so the mover is !turn_q
    always_comb begin
        mover_bits = turn_q ? board_x_q : board_o_q;
        line_hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int kind = 0; kind < 2; kind++) begin
                if ((mover_bits & line_mask(kind, k)) == line_mask(kind, k)) line_hit = 1'b1;
            end
        end
        for (int kind = 2; kind < 4; kind++) begin
            if ((mover_bits & line_mask(kind, 0)) == line_mask(kind, 0)) line_hit = 1'b1;
        end
    end

    always_comb begin
        range_bad = (int'(move_row) >= N) || (int'(move_col) >= N);
        cell_idx  = int'(move_row) * N + int'(move_col);
        cell_mask = NN'(1) << cell_idx;
        occupied  = |((board_x_q | board_o_q) & cell_mask);
    end

    // next-state and datapath
    always_comb begin
        state_d        = state_q;
        board_x_d      = board_x_q;
        board_o_d      = board_o_q;
        turn_d         = turn_q;
        move_count_d   = move_count_q;
        err_range_d    = 1'b0;
        err_occupied_d = 1'b0;
        err_turn_d     = 1'b0;
        win_x_d        = win_x_q;
        win_o_d        = win_o_q;
        draw_d         = draw_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_PLAY;
                    board_x_d    = '0;
                    board_o_d    = '0;
                    turn_d       = 1'b0;
                    move_count_d = '0;
                    win_x_d      = 1'b0;
                    win_o_d      = 1'b0;
                    draw_d       = 1'b0;
                end
            end
            S_PLAY: begin
                if (move_valid) begin
                    if (range_bad) begin
                        err_range_d = 1'b1;
`ifdef TTT_FORFEIT_EN
                        // out-of-range has no trustworthy mover: opponent of turn wins
                        state_d = S_DONE;
                        {win_o_d, win_x_d} = turn_q ? 2'b01 : 2'b10;
`endif
                    end else if (occupied || (move_player != turn_q)) begin
                        err_occupied_d = occupied;
                        err_turn_d     = !occupied;
`ifdef TTT_FORFEIT_EN
                        state_d = S_DONE;
                        {win_o_d, win_x_d} = move_player ? 2'b01 : 2'b10;
`endif
                    end else begin
                        if (move_player) board_o_d = board_o_q | cell_mask;
                        else             board_x_d = board_x_q | cell_mask;
                        move_count_d = move_count_q + MCW'(1);
                        turn_d       = !turn_q;
                        state_d      = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (line_hit) begin
                    if (turn_q) win_x_d = 1'b1;
                    else        win_o_d = 1'b1;
                    state_d = S_DONE;
                end else if (move_count_q == MCW'(NN)) begin
                    draw_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            board_x_q      <= '0;
            board_o_q      <= '0;
            turn_q         <= 1'b0;
            move_count_q   <= '0;
            err_range_q    <= 1'b0;
            err_occupied_q <= 1'b0;
            err_turn_q     <= 1'b0;
            win_x_q        <= 1'b0;
            win_o_q        <= 1'b0;
            draw_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_x_q      <= board_x_d;
            board_o_q      <= board_o_d;
            turn_q         <= turn_d;
            move_count_q   <= move_count_d;
            err_range_q    <= err_range_d;
            err_occupied_q <= err_occupied_d;
            err_turn_q     <= err_turn_d;
            win_x_q        <= win_x_d;
            win_o_q        <= win_o_d;
            draw_q         <= draw_d;
        end
    end

    // outputs: pure decodes of registered state
    always_comb begin
        move_ready   = (state_q == S_PLAY);
        game_over    = (state_q == S_DONE);
        board_x      = board_x_q;
        board_o      = board_o_q;
        turn         = turn_q;
        move_count   = move_count_q;
        err_range    = err_range_q;
        err_occupied = err_occupied_q;
        err_turn     = err_turn_q;
        win_x        = win_x_q;
        win_o        = win_o_q;
        draw         = draw_q;
    end
endmodule
